reg_writeback: RTL and testbench
================================

Name: reg_writeback

Overview:
Writeback stage directly upstream of the 32x32 register file in the multi-cycle CPU.
- Accepts one retiring instruction from the execute/memory stage through a valid/ready handshake.
- For loads, waits on the memory read-data handshake, then aligns and sign/zero-extends the data.
- Drives the register file write port (wen/waddr/wdata) for exactly one cycle per instruction.
- Keeps a retired-writeback counter for performance monitoring.

Parameters:
DATA_WIDTH, 32, datapath and register width
ADDR_WIDTH, 5, register index width
CNT_WIDTH, 32, width of writeback counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  upstream instruction valid
in_ready  out  1  stage can accept an instruction
in_rd  in  ADDR_WIDTH  destination register index
in_reg_write  in  1  instruction writes a register
in_is_load  in  1  result comes from memory
in_load_type  in  3  funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
in_addr_lo  in  2  low bits of load address (byte offset)
in_alu_result  in  DATA_WIDTH  result for non-load instructions
Read_data  in  DATA_WIDTH  memory read word
Read_data_Valid  in  1  memory read data valid
Read_data_Ready  out  1  stage accepts read data
rf_wen  out  1  register file write enable
rf_waddr  out  ADDR_WIDTH  register file write address
rf_wdata  out  DATA_WIDTH  register file write data
wb_done  out  1  one-cycle pulse, instruction retired
wb_count  out  CNT_WIDTH  number of retired instructions

Behaviour:
- Reset:
  - state=IDLE.
  - All latched fields and wb_count cleared to 0.
  - Output values on the cycle after reset: rf_wen=0, rf_waddr=0, rf_wdata=0, Read_data_Ready=0, wb_done=0, in_ready=1.
  - Reset in any state, including WAIT_MEM, aborts the instruction with no register write.
- FSM states: IDLE, WAIT_MEM, WRITE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch rd, reg_write, load_type, addr_lo and alu_result.
  - Next state: WAIT_MEM if in_is_load, else WRITE.
- WAIT_MEM:
  - Read_data_Ready=1, in_ready=0.
  - On Read_data_Valid: latch the aligned data and go to WRITE.
  - Otherwise stay, with no timeout.
- WRITE:
  - wb_done=1 for exactly one cycle; wb_count increments by 1 and wraps modulo 2^CNT_WIDTH.
  - rf_wen = latched reg_write AND (rd != 0).
  - rf_waddr = latched rd; rf_wdata = latched result.
  - Next state: IDLE unconditionally.
- Outputs are decoded from the registered state and fields: no combinational path from in_* or Read_data to rf_*.
- rf_waddr/rf_wdata hold their last values outside WRITE; only rf_wen gates the write.
- Latency:
  - Non-load accepted at edge N: rf_wen high in cycle N+1; the value is readable from the register file from cycle N+2.
  - Load data accepted at edge M: rf_wen high in cycle M+1.
  - Throughput: one instruction per 2 cycles for non-loads, at least 3 cycles for loads.
- Load alignment (little-endian):
  - Byte = Read_data[8*addr_lo +: 8].
  - Halfword = Read_data[16*addr_lo[1] +: 16]; addr_lo[0] is ignored.
  - LW ignores addr_lo.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Undefined load_type codes (011, 110, 111) produce the full word unmodified.
- Simultaneous events:
  - in_valid while not IDLE is not accepted; upstream holds it.
  - Read_data_Valid outside WAIT_MEM is ignored.

Decomposition:
- Shared package:
  - DATA_WIDTH/ADDR_WIDTH constants.
  - Load funct3 codes: LB, LH, LW, LBU, LHU.
  - FSM state encoding (2 bits: IDLE=0, WAIT_MEM=1, WRITE=2).
- One combinational sub-module, load_align:
  - Inputs: Read_data, load_type, addr_lo.
  - Output: aligned, extended word.
  - Reused by the future pipelined CPU.

Test Plan:
1. ALU writeback: rd=5, reg_write=1, alu_result=0xDEADBEEF, accepted at edge N -> cycle N+1 has rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF, wb_done=1; wb_count=1 afterwards.
2. LB sign extension: Read_data=0x12F45678, addr_lo=2 -> rf_wdata=0xFFFFFFF4. LBU with the same data -> 0x000000F4. LHU with addr_lo=2 -> 0x000012F4.
3. Delayed memory: Read_data_Valid asserted 5 cycles after entering WAIT_MEM -> Read_data_Ready stays 1 throughout, in_ready stays 0, rf_wen stays 0, and rf_wen rises exactly one cycle after the Valid edge.
4. rd=0 with reg_write=1 -> rf_wen=0, but wb_done=1 and wb_count increments. A load with reg_write=0 -> no write.
5. rst asserted for one cycle while in WAIT_MEM, then Read_data_Valid=1 -> no rf_wen, wb_count=0, state returns to IDLE with in_ready=1.
6. Back-to-back: in_valid held high for 3 non-load instructions -> accepted on alternating cycles, 3 wb_done pulses, wb_count=3, and register contents match the alu_result values.

Source files
------------

// File: rtl/reg_writeback_pkg.sv
// reg_writeback_pkg: shared widths, load funct3 codes and writeback FSM encoding.
package reg_writeback_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    WRITE    = 2'd2
  } state_e;
endpackage

// File: rtl/reg_writeback_load_align.sv
// load_align: little-endian byte/halfword select with sign or zero extension.
module load_align
  import reg_writeback_pkg::*;
#(
  parameter int DATA_WIDTH = reg_writeback_pkg::DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] read_data_i,
  input  logic [2:0]            load_type_i,
  input  logic [1:0]            addr_lo_i,
  output logic [DATA_WIDTH-1:0] aligned_o
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = read_data_i[{addr_lo_i, 3'b000} +: 8];
    h = read_data_i[{addr_lo_i[1], 4'b0000} +: 16];
    aligned_o = load_type_i == LB  ? {{(DATA_WIDTH-8){b[7]}}, b} :
                load_type_i == LH  ? {{(DATA_WIDTH-16){h[15]}}, h} :
                load_type_i == LBU ? {{(DATA_WIDTH-8){1'b0}}, b} :
                load_type_i == LHU ? {{(DATA_WIDTH-16){1'b0}}, h} :
                read_data_i;
  end
endmodule

// File: rtl/reg_writeback.sv
// reg_writeback: retires one instruction into the register file, waiting on memory for loads.
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int DATA_WIDTH = reg_writeback_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = reg_writeback_pkg::ADDR_WIDTH,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic                  in_reg_write,
  input  logic                  in_is_load,
  input  logic [2:0]            in_load_type,
  input  logic [1:0]            in_addr_lo,
  input  logic [DATA_WIDTH-1:0] in_alu_result,
  input  logic [DATA_WIDTH-1:0] Read_data,
  input  logic                  Read_data_Valid,
  output logic                  Read_data_Ready,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  wb_done,
  output logic [CNT_WIDTH-1:0]  wb_count
);
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d, waddr_q;
  logic                  rw_q, rw_d;
  logic [2:0]            lt_q, lt_d;
  logic [1:0]            lo_q, lo_d;
  logic [DATA_WIDTH-1:0] res_q, res_d, wdata_q, aligned;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  load_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .read_data_i(Read_data),
    .load_type_i(lt_q),
    .addr_lo_i  (lo_q),
    .aligned_o  (aligned)
  );

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    rw_d    = rw_q;
    lt_d    = lt_q;
    lo_d    = lo_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (in_valid) begin
        rd_d    = in_rd;
        rw_d    = in_reg_write;
        lt_d    = in_load_type;
        lo_d    = in_addr_lo;
        res_d   = in_alu_result;
        state_d = in_is_load ? WAIT_MEM : WRITE;
      end
      WAIT_MEM: if (Read_data_Valid) begin
        res_d   = aligned;
        state_d = WRITE;
      end
      WRITE: begin
        cnt_d   = cnt_q + CNT_WIDTH'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Write port address/data are captured only on entry to WRITE so they hold between writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rd_q    <= '0;
      rw_q    <= 1'b0;
      lt_q    <= '0;
      lo_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
      lt_q    <= lt_d;
      lo_q    <= lo_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      waddr_q <= state_d == WRITE ? rd_d : waddr_q;
      wdata_q <= state_d == WRITE ? res_d : wdata_q;
    end
  end

  assign in_ready        = state_q == IDLE;
  assign Read_data_Ready = state_q == WAIT_MEM;
  assign wb_done         = state_q == WRITE;
  assign rf_wen          = wb_done && rw_q && (rd_q != '0);
  assign rf_waddr        = waddr_q;
  assign rf_wdata        = wdata_q;
  assign wb_count        = cnt_q;
endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: vector table, hand-written corner sequences and random loads/ALU ops against a reference model.
module tb_reg_writeback;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_reg_write, in_is_load;
  logic [4:0]  in_rd;
  logic [2:0]  in_load_type;
  logic [1:0]  in_addr_lo;
  logic [31:0] in_alu_result, Read_data;
  logic        Read_data_Valid, Read_data_Ready;
  logic        rf_wen, wb_done;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, wb_count;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_cnt = 0;
  logic [31:0] rf [32];

  typedef struct {
    logic        ld;
    logic [2:0]  lt;
    logic [1:0]  lo;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] alu;
    logic [31:0] rdat;
    int          dly;
    logic [31:0] ew;
  } vec_t;
  vec_t tbl [14];

  reg_writeback dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd),
    .in_reg_write(in_reg_write), .in_is_load(in_is_load),
    .in_load_type(in_load_type), .in_addr_lo(in_addr_lo),
    .in_alu_result(in_alu_result),
    .Read_data(Read_data), .Read_data_Valid(Read_data_Valid),
    .Read_data_Ready(Read_data_Ready),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .wb_done(wb_done), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rf_wen) rf[rf_waddr] <= rf_wdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_align(input logic [31:0] d, input logic [2:0] t, input logic [1:0] lo);
    int unsigned b, h, sh;
    sh = 8 * int'(lo);
    b = (d >> sh) % 256;
    sh = 16 * (int'(lo) / 2);
    h = (d >> sh) % 65536;
    case (t)
      3'b000:  return b >= 128 ? b + 32'hFFFF_FF00 : b;
      3'b001:  return h >= 32768 ? h + 32'hFFFF_0000 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return d;
    endcase
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge after the WRITE cycle.
  task automatic exec(input string nm, input vec_t v);
    logic ewen;
    ewen = v.rw && (v.rd != 5'd0);
    chk({nm, " in_ready idle"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_is_load = v.ld; in_load_type = v.lt; in_addr_lo = v.lo;
    in_rd = v.rd; in_reg_write = v.rw; in_alu_result = v.alu;
    Read_data = $urandom; Read_data_Valid = v.ld ? 1'b0 : 1'($urandom % 2);
    @(negedge clk);
    in_valid = 1'b0; in_rd = 5'($urandom); in_reg_write = 1'($urandom);
    in_load_type = 3'($urandom); in_addr_lo = 2'($urandom); in_alu_result = $urandom;
    Read_data_Valid = 1'b0;
    if (v.ld) begin
      for (int c = 0; c < v.dly; c++) begin
        chk({nm, " wait rdy"}, 32'(Read_data_Ready), 32'd1);
        chk({nm, " wait in_ready"}, 32'(in_ready), 32'd0);
        chk({nm, " wait wen"}, 32'(rf_wen), 32'd0);
        Read_data = $urandom;
        @(negedge clk);
      end
      chk({nm, " rdy at valid"}, 32'(Read_data_Ready), 32'd1);
      Read_data = v.rdat; Read_data_Valid = 1'b1;
      @(negedge clk);
      Read_data_Valid = 1'b0; Read_data = $urandom;
    end
    exp_cnt++;
    chk({nm, " wb_done"}, 32'(wb_done), 32'd1);
    chk({nm, " wen"}, 32'(rf_wen), 32'(ewen));
    chk({nm, " waddr"}, 32'(rf_waddr), 32'(v.rd));
    chk({nm, " wdata"}, rf_wdata, v.ew);
    @(negedge clk);
    chk({nm, " done off"}, 32'(wb_done), 32'd0);
    chk({nm, " count"}, wb_count, 32'(exp_cnt));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_rd = '0; in_reg_write = 1'b0; in_is_load = 1'b0;
    in_load_type = '0; in_addr_lo = '0; in_alu_result = '0; Read_data = '0; Read_data_Valid = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset wen", 32'(rf_wen), 32'd0);
    chk("reset waddr", 32'(rf_waddr), 32'd0);
    chk("reset wdata", rf_wdata, 32'd0);
    chk("reset rdy", 32'(Read_data_Ready), 32'd0);
    chk("reset done", 32'(wb_done), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset count", wb_count, 32'd0);

    tbl[0]  = '{1'b0, 3'b000, 2'd0, 5'd5,  1'b1, 32'hDEADBEEF, 32'h0,        0, 32'hDEADBEEF};
    tbl[1]  = '{1'b1, 3'b000, 2'd2, 5'd6,  1'b1, 32'h0,        32'h12F45678, 0, 32'hFFFFFFF4};
    tbl[2]  = '{1'b1, 3'b100, 2'd2, 5'd7,  1'b1, 32'h0,        32'h12F45678, 1, 32'h000000F4};
    tbl[3]  = '{1'b1, 3'b101, 2'd2, 5'd8,  1'b1, 32'h0,        32'h12F45678, 2, 32'h000012F4};
    tbl[4]  = '{1'b1, 3'b001, 2'd0, 5'd9,  1'b1, 32'h0,        32'h12F48678, 0, 32'hFFFF8678};
    tbl[5]  = '{1'b1, 3'b001, 2'd3, 5'd10, 1'b1, 32'h0,        32'h80011234, 0, 32'hFFFF8001};
    tbl[6]  = '{1'b1, 3'b101, 2'd1, 5'd11, 1'b1, 32'h0,        32'hABCD1234, 0, 32'h00001234};
    tbl[7]  = '{1'b1, 3'b010, 2'd3, 5'd12, 1'b1, 32'h0,        32'hCAFEBABE, 5, 32'hCAFEBABE};
    tbl[8]  = '{1'b1, 3'b011, 2'd1, 5'd13, 1'b1, 32'h0,        32'h89ABCDEF, 0, 32'h89ABCDEF};
    tbl[9]  = '{1'b1, 3'b111, 2'd2, 5'd14, 1'b1, 32'h0,        32'h00FF00FF, 0, 32'h00FF00FF};
    tbl[10] = '{1'b1, 3'b000, 2'd1, 5'd15, 1'b1, 32'h0,        32'h00007F00, 0, 32'h0000007F};
    tbl[11] = '{1'b1, 3'b000, 2'd3, 5'd16, 1'b1, 32'h0,        32'h80000000, 0, 32'hFFFFFF80};
    tbl[12] = '{1'b0, 3'b000, 2'd0, 5'd0,  1'b1, 32'h11112222, 32'h0,        0, 32'h11112222};
    tbl[13] = '{1'b1, 3'b010, 2'd0, 5'd17, 1'b0, 32'h0,        32'h55667788, 1, 32'h55667788};
    for (int i = 0; i < 14; i++) exec($sformatf("vec%0d", i), tbl[i]);

    // Reset while waiting on memory aborts the load and clears the counter.
    in_valid = 1'b1; in_is_load = 1'b1; in_rd = 5'd20; in_reg_write = 1'b1; in_load_type = 3'b010;
    @(negedge clk);
    in_valid = 1'b0;
    chk("abort in WAIT_MEM", 32'(Read_data_Ready), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; Read_data_Valid = 1'b1; Read_data = 32'hA5A5A5A5;
    exp_cnt = 0;
    chk("abort in_ready", 32'(in_ready), 32'd1);
    chk("abort rdy", 32'(Read_data_Ready), 32'd0);
    @(negedge clk);
    Read_data_Valid = 1'b0;
    chk("abort wen", 32'(rf_wen), 32'd0);
    chk("abort done", 32'(wb_done), 32'd0);
    chk("abort count", wb_count, 32'd0);
    chk("abort in_ready2", 32'(in_ready), 32'd1);

    // Back-to-back ALU ops with in_valid held high.
    in_valid = 1'b1; in_is_load = 1'b0; in_reg_write = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("b2b%0d accept", k), 32'(in_ready), 32'd1);
      in_rd = 5'(21 + k); in_alu_result = 32'h1000_0000 * (k + 1) + 32'(k);
      @(negedge clk);
      exp_cnt++;
      chk($sformatf("b2b%0d busy", k), 32'(in_ready), 32'd0);
      chk($sformatf("b2b%0d done", k), 32'(wb_done), 32'd1);
      chk($sformatf("b2b%0d waddr", k), 32'(rf_waddr), 32'(21 + k));
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("b2b count", wb_count, 32'd3);
    for (int k = 0; k < 3; k++)
      chk($sformatf("b2b rf%0d", 21 + k), rf[21 + k], 32'h1000_0000 * (k + 1) + 32'(k));

    for (int i = 0; i < 40; i++) begin
      vec_t v;
      v.ld = 1'($urandom % 2); v.lt = 3'($urandom); v.lo = 2'($urandom);
      v.rd = 5'($urandom); v.rw = 1'($urandom % 4 != 0); v.alu = $urandom;
      v.rdat = $urandom; v.dly = int'($urandom_range(0, 3));
      v.ew = v.ld ? ref_align(v.rdat, v.lt, v.lo) : v.alu;
      exec($sformatf("rnd%0d", i), v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
